// File: rtl/aes_key_expander.sv
// aes_key_expander: sequential AES-128 key schedule, streams round keys 0..NUM_ROUNDS under backpressure.
// Optional KEY_EXP_STORE_EN adds a round-key register file (rd_idx/rd_key/store_full) for reverse-order reads.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Same forward S-box table as the round datapath SubBytes.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];
endmodule

module aes_key_expander #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_last
`ifdef KEY_EXP_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         store_full
`endif
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state;
  logic [7:0] rcon;

  logic [31:0] w0, w1, w2, w3, rot_w3, t;
  logic [31:0] n0, n1, n2, n3;
  logic [NUM_LANES-1:0][VEC_W-1:0] sub_w;
  logic hs;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign {w0, w1, w2, w3} = rk_out;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  // One S-box per byte lane; the only SubWord instance in the block.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_sub
    aes_sbox u_sbox (.a(rot_w3[i*VEC_W +: VEC_W]), .y(sub_w[i]));
  end

  assign t  = sub_w ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign hs = rk_valid & rk_ready;

  // key_ready/rk_valid/rk_last are registered so neither handshake input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_out    <= '0;
      rk_idx    <= '0;
      rk_last   <= 1'b0;
      rcon      <= 8'h01;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            state     <= RUN;
            key_ready <= 1'b0;
            rk_valid  <= 1'b1;
            rk_out    <= key_in;
            rk_idx    <= '0;
            rk_last   <= (LAST_IDX == 4'd0);
            rcon      <= 8'h01;
          end
        end
        RUN: begin
          if (hs) begin
            if (rk_idx == LAST_IDX) begin
              state     <= IDLE;
              key_ready <= 1'b1;
              rk_valid  <= 1'b0;
              rk_last   <= 1'b0;
            end else begin
              rk_out  <= {n0, n1, n2, n3};
              rk_idx  <= rk_idx + 4'd1;
              rk_last <= (rk_idx + 4'd1 == LAST_IDX);
              rcon    <= xtime(rcon);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_EXP_STORE_EN
  logic [127:0] store [NUM_ROUNDS+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
      store_full <= 1'b0;
    end else begin
      if (state == IDLE && key_valid) store_full <= 1'b0;
      if (hs) begin
        for (int i = 0; i <= NUM_ROUNDS; i++)
          if (rk_idx == 4'(i)) store[i] <= rk_out;
        if (rk_idx == LAST_IDX) store_full <= 1'b1;
      end
    end
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++)
      if (rd_idx == 4'(i)) rd_key = store[i];
  end
`endif

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
Sequential AES-128 key schedule. Sits directly upstream of the round datapath and feeds it one 128-bit round key per handshake.
- Accepts a cipher key through a valid/ready handshake.
- Streams round keys 0..NUM_ROUNDS in order, under downstream backpressure.
- Generates each key from the previous one with one shared SubWord unit, so no 11-entry table is needed in the base build.

Parameters:
NUM_ROUNDS, 10, index of the last round key emitted; legal range 1..10; 10 = standard AES-128.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
key_valid  input  1  key_in is valid this cycle.
key_ready  output  1  block can accept a new key.
key_in  input  128  cipher key; [127:120] = byte 0, i.e. MSB of word w0.
rk_valid  output  1  rk_out holds a valid round key.
rk_ready  input  1  downstream consumes rk_out this cycle.
rk_out  output  128  current round key; same byte order as key_in.
rk_idx  output  4  round index of rk_out, 0..NUM_ROUNDS.
rk_last  output  1  high while rk_idx == NUM_ROUNDS and rk_valid.

Behaviour:
- Reset (async assert, sync deassert edge not required):
  - state = IDLE.
  - key_ready = 1, rk_valid = 0, rk_out = 0, rk_idx = 0, rk_last = 0.
  - rcon register = 8'h01.
- State IDLE:
  - key_ready = 1, rk_valid = 0.
  - On key_valid && key_ready: rk_out <= key_in, rk_idx <= 0, rcon <= 8'h01, go to RUN.
- State RUN:
  - key_ready = 0, rk_valid = 1.
  - rk_out holds round key rk_idx and is stable until the handshake.
- RUN, on rk_valid && rk_ready with rk_idx < NUM_ROUNDS:
  - rk_out <= next key; rk_idx <= rk_idx + 1; rcon <= xtime(rcon).
  - xtime: shift left 1, XOR 8'h1B if bit 7 was set. The sequence is 01,02,04,08,10,20,40,80,1B,36.
- RUN, on handshake with rk_idx == NUM_ROUNDS: go to IDLE; rk_valid = 0 the next cycle; key_ready = 1 the next cycle.
- Next-key arithmetic, with current words w0..w3 (w0 = rk_out[127:96]):
  - t = SubWord(RotWord(w3)) XOR {rcon, 24'h0}.
  - RotWord rotates left by one byte.
  - SubWord applies the AES S-box bytewise, using the same S-box table as the round datapath SubBytes.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - All combinational from registers; one register update per handshake.
- Latency:
  - Key accepted at edge N: round key 0 is valid after edge N.
  - With rk_ready held high, key k appears after edge N+k.
  - NUM_ROUNDS+1 cycles total, then 1 IDLE cycle before the next key can be accepted.
- Backpressure: while rk_valid && !rk_ready, rk_out, rk_idx, rk_last and rcon hold.
- key_valid asserted while in RUN is ignored (key_ready = 0); key_in is not sampled.
- No combinational path from rk_ready to rk_valid, or from key_valid to key_ready. All outputs are registered or decoded from state only.
- rst_n asserted mid-RUN: immediate return to reset values; the partial schedule is discarded and no further rk_valid is produced.

Optional Feature:
KEY_EXP_STORE_EN
- Defined: adds a (NUM_ROUNDS+1) x 128 register file written with each round key as it is emitted.
- Added ports (present only when defined):
  - rd_idx input 4.
  - rd_key output 128, combinational read of entry rd_idx; reads 0 if rd_idx > NUM_ROUNDS.
  - store_full output 1.
- store_full behaviour:
  - Set on the handshake of the last key.
  - Cleared on acceptance of a new key and on reset.
  - Entries reset to 0.
- This lets a decryptor fetch keys in reverse order.
- Undefined: no storage and no extra ports; streaming behaviour is identical.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_out sequence:
   - idx0 = key.
   - idx1 = a0fafe1788542cb123a339392a6c7605.
   - idx2 = f2c295f27a96b9435935807a7359f67f.
   - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last=1.
   - 11 consecutive valid cycles, then IDLE.
2. Same key, rk_ready toggled pseudo-randomly -> same 11 keys in order, each held stable while stalled, none skipped or duplicated.
3. key_valid pulsed with a different key during RUN -> ignored; schedule of the first key completes unchanged; key_ready=0 throughout RUN.
4. rst_n low at idx 4 -> rk_valid=0 and key_ready=1 immediately. A new key 000102030405060708090a0b0c0d0e0f then yields idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
5. Back-to-back keys with key_valid held high -> second key accepted exactly one cycle after the idx10 handshake.
6. With KEY_EXP_STORE_EN, after test 1 -> store_full=1; rd_idx=10 reads d014f9a8...; rd_idx=0 reads the cipher key; rd_idx=12 reads 0.
